// File: rtl/int_fp_mul_arb.sv
// Round-robin arbiter/sequencer that time-shares one int_fp_mul among N requesters.
// Operands are held on mul_mode/a/b from accept until the result is captured into the response register.
module int_fp_mul_arb #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   output logic [N-1:0]      req_ready,
   input  logic [N-1:0]      req_mode,
   input  logic [16*N-1:0]   req_a,
   input  logic [16*N-1:0]   req_b,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [15:0]       rsp_data,
   output logic              mul_rst,
   output logic              mul_mode,
   output logic [15:0]       mul_a,
   output logic [15:0]       mul_b,
   input  logic [15:0]       mul_c
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
   // requesters hold valid and payload stable until that edge, ready never waits on anything but state.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_EXEC    = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   last_q, last_d;
   logic [IDW-1:0]   id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [15:0]      rsp_data_q, rsp_data_d;
   logic             mul_mode_q, mul_mode_d;
   logic [15:0]      mul_a_q, mul_a_d;
   logic [15:0]      mul_b_q, mul_b_d;

   logic             gnt_found;
   logic [IDW-1:0]   gnt_idx;
   logic [IDW-1:0]   cand;

   // Scan starts just after the last winner, so the previous winner has lowest priority.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= N; k++) begin
         cand = IDW'((int'(last_q) + k) % N);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && gnt_found && !rst) begin
         req_ready = N'(1) << gnt_idx;
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      mul_mode_d  = mul_mode_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;

      if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               mul_mode_d = req_mode[gnt_idx];
               mul_a_d    = req_a[16*gnt_idx +: 16];
               mul_b_d    = req_b[16*gnt_idx +: 16];
               id_d       = gnt_idx;
               last_d     = gnt_idx;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_EXEC;
         S_EXEC:  state_d = S_CAPTURE;
         S_CAPTURE: begin
            // A consume and a reload on the same edge leave rsp_valid high with the new data.
            if (!rsp_valid_q || rsp_ready) begin
               rsp_data_d  = mul_c;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_q      <= IDW'(N - 1);
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         mul_mode_q  <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         mul_mode_q  <= mul_mode_d;
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
      end
   end

   assign mul_rst   = ~rst;
   assign mul_mode  = mul_mode_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_int_fp_mul_arb.sv
// Bench for int_fp_mul_arb: stand-in two-stage multiplier, per-requester drivers,
// and a monitor that scoreboards grants, response timing and response contents.
module tb_int_fp_mul_arb;

   localparam int N   = 4;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N-1:0]      req_mode;
   logic [16*N-1:0]   req_a;
   logic [16*N-1:0]   req_b;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [IDW-1:0]    rsp_id;
   logic [15:0]       rsp_data;
   logic              mul_rst;
   logic              mul_mode;
   logic [15:0]       mul_a;
   logic [15:0]       mul_b;
   logic [15:0]       mul_c;

   logic              v_arr [N];
   logic              m_arr [N];
   logic [15:0]       a_arr [N];
   logic [15:0]       b_arr [N];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic rand_rdy_en = 1'b0;

   int_fp_mul_arb #(.N(N), .IDW(IDW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .mul_rst(mul_rst), .mul_mode(mul_mode), .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      for (int i = 0; i < N; i++) begin
         v_arr[i] = 1'b0; m_arr[i] = 1'b0; a_arr[i] = '0; b_arr[i] = '0;
      end
   end

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_valid[i]        = v_arr[i];
         req_mode[i]         = m_arr[i];
         req_a[16*i +: 16]   = a_arr[i];
         req_b[16*i +: 16]   = b_arr[i];
      end
   end

   // ---------------- reference arithmetic ----------------
   function automatic logic [15:0] ref_mul(input logic m, input logic [15:0] a, input logic [15:0] b);
      logic [21:0] p;
      int          e;
      logic [9:0]  f;
      logic        s;
      if (!m) return 16'(a[7:0]) * 16'(b[7:0]);
      s = a[15] ^ b[15];
      if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'd0};
      p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
      e = int'(a[14:10]) + int'(b[14:10]) - 15;
      if (p[21]) begin
         e = e + 1;
         f = p[20:11];
      end else begin
         f = p[19:10];
      end
      return {s, e[4:0], f};
   endfunction

   // Stand-in multiplier: inputs registered at end of ISSUE, result at end of EXEC.
   // A result computed while the live operands differ from the registered ones is poisoned.
   logic        s1_m;
   logic [15:0] s1_a, s1_b;
   always @(posedge clk) begin
      if (!mul_rst) begin
         s1_m <= 1'b0; s1_a <= '0; s1_b <= '0; mul_c <= '0;
      end else begin
         s1_m  <= mul_mode;
         s1_a  <= mul_a;
         s1_b  <= mul_b;
         mul_c <= (s1_m == mul_mode && s1_a == mul_a && s1_b == mul_b) ?
                  ref_mul(s1_m, s1_a, s1_b) : 16'hFFFF;
      end
   end

   always @(posedge clk) begin
      if (rand_rdy_en) begin
         #1;
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // ---------------- scoreboard / monitor ----------------
   logic [IDW+15:0] exp_q [$];
   int   g_id_q [$];
   int   g_cyc_q [$];
   int   model_last = N - 1;
   logic model_v = 1'b0;
   logic prev_v = 1'b0;
   logic prev_c = 1'b0;
   logic expect_load = 1'b0;
   logic pend = 1'b0;
   int   pend_cyc = 0;
   logic loaded;
   logic [IDW+15:0] e_ent;
   int   w, g;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         model_last  = N - 1;
         model_v     = 1'b0;
         prev_v      = 1'b0;
         prev_c      = 1'b0;
         expect_load = 1'b0;
         pend        = 1'b0;
      end else begin
         loaded = rsp_valid && (!prev_v || prev_c);
         if (loaded || expect_load) begin
            check("rsp_load_cycle", 32'(loaded), 32'(expect_load));
            if (expect_load && exp_q.size() != 0) begin
               e_ent = exp_q.pop_front();
               if (loaded) begin
                  check("rsp_id", 32'(rsp_id), 32'(e_ent[IDW+15:16]));
                  check("rsp_data", 32'(rsp_data), 32'(e_ent[15:0]));
               end
            end
         end
         check("rsp_valid", 32'(rsp_valid), 32'(model_v));
         prev_v = rsp_valid;
         prev_c = rsp_valid && rsp_ready;

         // Result is ready in the third cycle after accept; it loads once the register is free.
         expect_load = pend && (cyc >= pend_cyc + 3) && (!model_v || rsp_ready);
         if (expect_load) pend = 1'b0;
         model_v = expect_load ? 1'b1 : ((model_v && rsp_ready) ? 1'b0 : model_v);

         if (req_ready != '0) begin
            check("ready_onehot", 32'($onehot(req_ready) && ((req_ready & ~req_valid) == '0)), 32'd1);
            check("grant_while_busy", 32'(pend || expect_load), 32'd0);
            w = -1;
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (model_last + k) % N;
               if (w < 0 && req_valid[c]) w = c;
            end
            g = 0;
            for (int i = N - 1; i >= 0; i--) if (req_ready[i]) g = i;
            check("grant_order", 32'(g), 32'(w));
            model_last = g;
            exp_q.push_back({IDW'(g), ref_mul(req_mode[g], req_a[16*g +: 16], req_b[16*g +: 16])});
            pend     = 1'b1;
            pend_cyc = cyc;
            g_id_q.push_back(g);
            g_cyc_q.push_back(cyc);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input int i, input logic m, input logic [15:0] a, input logic [15:0] b);
      int t;
      m_arr[i] = m; a_arr[i] = a; b_arr[i] = b; v_arr[i] = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!req_ready[i] && t < 400);
      check("send_handshake", 32'(req_ready[i]), 32'd1);
      @(posedge clk);
      #1;
      v_arr[i] = 1'b0;
   endtask

   task automatic gen_op(output logic m, output logic [15:0] a, output logic [15:0] b);
      m = 1'($urandom_range(0, 1));
      if (!m) begin
         a = 16'($urandom);
         b = 16'($urandom);
      end else begin
         a = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 3'($urandom_range(0, 7)), 7'd0};
         b = {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 3'($urandom_range(0, 7)), 7'd0};
         if ($urandom_range(0, 7) == 0) begin
            a = 16'd0;
            b[15] = 1'b0;
         end
      end
   endtask

   task automatic send_rand(input int i);
      logic m;
      logic [15:0] a, b;
      gen_op(m, a, b);
      send(i, m, a, b);
   endtask

   // Requires rsp_ready=1 and an idle arbiter; checks the 3-cycle accept-to-response path.
   task automatic send_and_check(input int i, input logic m, input logic [15:0] a,
                                 input logic [15:0] b, input logic [15:0] exp_d);
      send(i, m, a, b);
      repeat (2) @(posedge clk);
      #1;
      check("latency_early", 32'(rsp_valid && rsp_data == exp_d && rsp_id == IDW'(i) && !prev_c), 32'd0);
      @(posedge clk);
      #1;
      check("direct_valid", 32'(rsp_valid), 32'd1);
      check("direct_data", 32'(rsp_data), 32'(exp_d));
      check("direct_id", 32'(rsp_id), 32'(i));
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || pend) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   // ---------------- test sequence ----------------
   logic        am, bm, cm;
   logic [15:0] aa, ab, ba, bb, ca, cb;

   initial begin
      // 1: reset values with every requester valid, then requester 0 first
      rst = 1'b1;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         fork
            automatic int j = i;
            send_rand(j);
         join_none
      end
      repeat (2) begin
         @(negedge clk);
         check("rst_req_ready", 32'(req_ready), 32'd0);
         check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         check("rst_mul_a", 32'(mul_a), 32'd0);
         check("rst_mul_b", 32'(mul_b), 32'd0);
         check("rst_mul_mode", 32'(mul_mode), 32'd0);
         check("rst_mul_rst", 32'(mul_rst), 32'd0);
         check("rst_rsp_data", 32'(rsp_data), 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("first_grant_req0", 32'(req_ready), 32'b0001);
      wait fork;
      drain();

      // 2, 3: integer and FP multiplies with fixed operands
      send_and_check(2, 1'b0, 16'h00C8, 16'h0064, 16'h4E20);
      send_and_check(1, 1'b1, 16'h3E00, 16'h4000, 16'h4200);
      send_and_check(1, 1'b1, 16'h0000, 16'h4400, 16'h0000);
      drain();

      // 4: round-robin with all requesters continuously valid
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      g_id_q.delete();
      g_cyc_q.delete();
      for (int i = 0; i < N; i++) begin
         fork
            automatic int j = i;
            repeat (j == 0 ? 2 : 1) send_rand(j);
         join_none
      end
      wait fork;
      check("rr_count", 32'(g_id_q.size()), 32'd5);
      if (g_id_q.size() == 5) begin
         for (int k = 0; k < 5; k++) check("rr_order", 32'(g_id_q[k]), 32'(k % N));
         for (int k = 1; k < 5; k++) check("rr_spacing", 32'(g_cyc_q[k] - g_cyc_q[k-1]), 32'd4);
      end
      drain();

      // 5: backpressure with a response pending and a second operation stalled in CAPTURE
      rsp_ready = 1'b0;
      gen_op(am, aa, ab);
      gen_op(bm, ba, bb);
      gen_op(cm, ca, cb);
      send(0, am, aa, ab);
      send(1, bm, ba, bb);
      fork
         begin
            repeat (3) @(negedge clk);
            repeat (6) begin
               check("stall_mul_a", 32'(mul_a), 32'(ba));
               check("stall_mul_b", 32'(mul_b), 32'(bb));
               check("stall_mul_mode", 32'(mul_mode), 32'(bm));
               check("stall_rsp_data", 32'(rsp_data), 32'(ref_mul(am, aa, ab)));
               check("stall_rsp_id", 32'(rsp_id), 32'd0);
               check("stall_no_grant", 32'(req_ready), 32'd0);
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
         end
         send(2, cm, ca, cb);
      join
      drain();

      // 6: reset while the operation is in EXEC
      send_rand(3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      check("abort_mul_a", 32'(mul_a), 32'd0);
      check("abort_idle", 32'(req_ready), 32'd0);
      repeat (4) @(negedge clk);
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk);
      #1;
      send_and_check(0, 1'b0, 16'h00FF, 16'h00FF, 16'hFE01);
      drain();

      // Randomized traffic with random response backpressure
      rand_rdy_en = 1'b1;
      for (int i = 0; i < N; i++) begin
         fork
            automatic int j = i;
            repeat (8) begin
               repeat ($urandom_range(0, 5)) @(posedge clk);
               #1;
               send_rand(j);
            end
         join_none
      end
      wait fork;
      rand_rdy_en = 1'b0;
      @(posedge clk);
      #2;
      rsp_ready = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
      $fatal(1, "watchdog");
   end

endmodule
